// File: rtl/button_event_pkg.sv
// Shared definitions for the pushbutton event block: state encoding and the
// system-wide tick rate produced by the common clock divider.
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } btn_state_e;

  // Clock cycles per tick strobe, shared by every button instance.
  localparam int unsigned TICK_DIV = 32'd500000;

endpackage

// File: rtl/button_event.sv
// Turns one debounced button level into registered single-cycle press,
// release, long-press and auto-repeat events, timed by a shared tick strobe.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  input  logic tick,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  btn_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             press_r, release_r, long_r, repeat_r, held_r;
  logic             press_s, release_s, long_s, repeat_s;

  // Next-state, counter and pulse decode; release always wins over tick.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    long_s    = 1'b0;
    repeat_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (btn_level) begin
          state_s = ST_PRESSED;
          cnt_s   = CNT_ZERO;
          press_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          state_s   = ST_IDLE;
          cnt_s     = CNT_ZERO;
          release_s = 1'b1;
        end else if (tick) begin
          if (cnt_r == LONG_LAST) begin
            state_s = ST_REPEAT;
            cnt_s   = CNT_ZERO;
            long_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_REPEAT: begin
        if (!btn_level) begin
          state_s   = ST_IDLE;
          cnt_s     = CNT_ZERO;
          release_s = 1'b1;
        end else if (tick) begin
          if (cnt_r == REPEAT_LAST) begin
            cnt_s    = CNT_ZERO;
            repeat_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops to IDLE with no release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      press_r   <= press_s;
      release_r <= release_s;
      long_r    <= long_s;
      repeat_r  <= repeat_s;
      held_r    <= (state_s != ST_IDLE);
    end
  end

  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign long_pulse    = long_r;
  assign repeat_pulse  = repeat_r;
  assign held          = held_r;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_TICKS=4, REPEAT_TICKS=2 and a
// tick on every 4th clock; outputs packed as {press,release,long,repeat,held}.
module tb_button_event;

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic tick;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  int n_checks = 0;
  int n_errors = 0;
  int n_press, n_rel, n_long, n_rep, n_overlap;
  logic [1:0] phase;

  button_event #(
    .LONG_TICKS  (4),
    .REPEAT_TICKS(2),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_level    (btn_level),
    .tick         (tick),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
    phase = 2'd0;
  endtask

  // One clock: tick on phase 3; afterwards outputs show this edge's response.
  task automatic step(input logic b);
    btn_level = b;
    tick      = (phase == 2'd3);
    phase     = phase + 2'd1;
    @(posedge clk);
    #1;
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_long  += int'(long_pulse);
    n_rep   += int'(repeat_pulse);
    if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse)) > 1)
      n_overlap++;
  endtask

  initial begin
    n_overlap = 0;
    reset = 1'b0; btn_level = 1'b0; tick = 1'b0;
    clear_counts();

    // 1. reset held with button pressed
    for (int i = 0; i < 5; i++) step(1'b1);
    check_eq("rst_outs", 32'(outs()), 32'h00);
    reset = 1'b1;
    step(1'b1);
    check_eq("rst_rel_press", 32'(outs()), 32'h11);
    step(1'b1);
    check_eq("rst_held", 32'(outs()), 32'h01);
    step(1'b0);
    check_eq("rst_release", 32'(outs()), 32'h08);
    step(1'b0);

    // 2. short press, one tick seen
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      if (i == 0) check_eq("short_press", 32'(outs()), 32'h11);
    end
    step(1'b0);
    check_eq("short_release", 32'(outs()), 32'h08);
    step(1'b0);
    check_eq("short_idle", 32'(outs()), 32'h00);
    check_eq("short_counts", {8'(n_press), 8'(n_rel), 8'(n_long), 8'(n_rep)}, 32'h01010000);

    // 3. long hold with auto-repeat
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      if (i == 14) check_eq("long_before", 32'(outs()), 32'h01);
      if (i == 15) check_eq("long_fire", 32'(outs()), 32'h05);
      if (i == 19) check_eq("rep_gap", 32'(outs()), 32'h01);
      if (i == 23 || i == 31 || i == 39) check_eq("rep_fire", 32'(outs()), 32'h03);
    end
    step(1'b0);
    check_eq("long_release", 32'(outs()), 32'h08);
    step(1'b0);
    check_eq("long_counts", {8'(n_press), 8'(n_rel), 8'(n_long), 8'(n_rep)}, 32'h01010103);

    // 4. release coincides with the 4th tick
    clear_counts();
    for (int i = 0; i < 15; i++) step(1'b1);
    step(1'b0);
    check_eq("tickrel_outs", 32'(outs()), 32'h08);
    step(1'b0);
    check_eq("tickrel_idle", 32'(outs()), 32'h00);
    check_eq("tickrel_long", 32'(n_long), 32'd0);

    // 5. reset while in REPEAT, button kept held
    clear_counts();
    for (int i = 0; i < 20; i++) step(1'b1);
    check_eq("midrst_pre", 32'(n_long), 32'd1);
    reset = 1'b0;
    step(1'b1);
    check_eq("midrst_outs", 32'(outs()), 32'h00);
    check_eq("midrst_norel", 32'(n_rel), 32'd0);
    reset = 1'b1;
    step(1'b1);
    check_eq("midrst_repress", 32'(outs()), 32'h11);
    step(1'b0);
    check_eq("midrst_release", 32'(outs()), 32'h08);
    step(1'b0);

    // 6. single-clock glitch, then a full hold to confirm the counter restarted
    clear_counts();
    step(1'b1);
    check_eq("glitch_press", 32'(outs()), 32'h11);
    step(1'b0);
    check_eq("glitch_release", 32'(outs()), 32'h08);
    step(1'b0);
    check_eq("glitch_idle", 32'(outs()), 32'h00);
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      step(1'b1);
      if (i == 15) check_eq("glitch_cnt_long", 32'(outs()), 32'h05);
    end
    step(1'b0);
    step(1'b0);

    // 7. tick on the press-accept cycle is not counted
    clear_counts();
    phase = 2'd3;
    for (int i = 0; i < 17; i++) begin
      step(1'b1);
      if (i == 12) check_eq("ovl_no_early", 32'(n_long), 32'd0);
      if (i == 16) check_eq("ovl_long", 32'(outs()), 32'h05);
    end
    step(1'b0);
    step(1'b0);

    check_eq("pulse_overlap", 32'(n_overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the clean, debounced level of one pushbutton and converts it into single-cycle events for the application FSMs.
- Events: press, release, long-press and auto-repeat.
- Sits between each per-button debouncer and game/menu control logic, so no control block does its own edge detection or hold timing.
- Hold timing counts an external slow tick strobe, not raw clocks.

Parameters:
- LONG_TICKS, 100, number of ticks held in PRESSED before long_pulse fires; must be >=1 and < 2^CNT_W.
- REPEAT_TICKS, 20, number of ticks between successive repeat_pulse events after the long press; must be >=1 and < 2^CNT_W.
- CNT_W, 8, width of the internal tick counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- btn_level  input  1  debounced button level, 1 = pressed, synchronous to clk.
- tick  input  1  one-clk-wide timebase strobe.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on release.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_TICKS.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_TICKS while held past long.
- held  output  1  level, 1 while state is PRESSED or REPEAT.

Behaviour:
- **Reset:** all logic samples at posedge clk only. When reset==0 at a clock edge:
  - state=IDLE, cnt=0.
  - All outputs are 0.
  - A button held through reset release is treated as a new press on the first active edge.
- **Pulse outputs:** registered, high for exactly one clk, with no combinational path from inputs.
- **held:** registered, equal to (next state != IDLE).
- **States:** IDLE, PRESSED, REPEAT.
- **IDLE:**
  - btn_level==1 -> PRESSED, cnt=0, press_pulse=1 in the following cycle. Latency is 1 clk from the first sampled high.
  - The tick input is ignored.
- **PRESSED:**
  - btn_level==0 -> IDLE, release_pulse=1, cnt=0.
  - Otherwise, if tick==1: if cnt==LONG_TICKS-1, go to REPEAT, set cnt=0 and long_pulse=1; else cnt=cnt+1.
- **REPEAT:**
  - btn_level==0 -> IDLE, release_pulse=1, cnt=0.
  - Otherwise, if tick==1: if cnt==REPEAT_TICKS-1, set cnt=0 and repeat_pulse=1; else cnt=cnt+1.
- **Simultaneous events:**
  - Release has priority over tick in the same cycle. No long or repeat pulse fires on the release cycle.
  - A press and release each lasting 1 clk gives press_pulse and then release_pulse on consecutive cycles. Both always fire as a pair.
- **Counter rules:**
  - cnt never wraps. It is cleared on every state change and every repeat_pulse.
  - Compare with equality against parameter-1, sized to CNT_W.
- **Pulse exclusivity:** at most one of press/release/long/repeat is high in any cycle.
- **Pulse timing:** long_pulse fires exactly LONG_TICKS ticks after the press was accepted. The first repeat_pulse fires REPEAT_TICKS ticks after long_pulse.
- **Tick overlap:** a tick in the same cycle the press is accepted (IDLE -> PRESSED) is not counted.
- **Reset mid-hold:** returns to IDLE immediately with no release_pulse.

Decomposition:
- Shared package/include holds:
  - The state encoding constants for IDLE/PRESSED/REPEAT (2-bit).
  - A common tick-rate constant used by all button instances.
- Single module with no sub-module. The tick strobe comes from the existing shared clock-divider block, one per design and not per button.

Test Plan (LONG_TICKS=4, REPEAT_TICKS=2, tick every 4th clk):
1. **Reset:** hold reset=0 with btn_level=1 for 5 clks -> all outputs 0. Release reset -> press_pulse=1 exactly 1 clk later, then held=1.
2. **Short press:** btn_level high for 6 clks, with 1 tick seen -> one press_pulse, then one release_pulse 1 clk after btn_level falls, no long_pulse, held back to 0.
3. **Long hold:** btn_level high for 40 clks ->
   - press_pulse at the start.
   - long_pulse on the clk after the 4th tick.
   - repeat_pulse after the 6th, 8th and 10th ticks.
   - release_pulse at the end.
   - Exactly 1 long and 3 repeats counted.
4. **Release on the tick cycle:** btn_level falls in the same cycle as the 4th tick -> release_pulse only, long_pulse never asserted.
5. **Reset mid-repeat:** assert reset=0 during REPEAT -> the next cycle has all outputs 0 and no release_pulse. With the button still held after reset release -> a fresh press_pulse.
6. **Single-clk glitch:** btn_level high for 1 clk -> press_pulse and release_pulse on consecutive cycles, never overlapping, cnt back to 0.
